// File: rtl/sc_collision_lives.sv
// Row-parallel player/obstacle collision detector with a lives counter,
// post-hit grace window and game-over latch.

module sc_collision_lives_row #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] player,
  input  logic [DATAWIDTH-1:0] obstacle,
  input  logic                 enable,
  output logic                 collide
);
  assign collide = enable & (|(player & obstacle));
endmodule

module sc_collision_lives #(
  parameter int DATAWIDTH = 8,
  parameter int NUMROWS   = 4,
  parameter int LIVES     = 3,
  parameter int GRACE     = 2
) (
  input  logic                         SC_COLLISIONLIVES_CLOCK_50,
  input  logic                         SC_COLLISIONLIVES_RESET_InHigh,
  input  logic [NUMROWS*DATAWIDTH-1:0] SC_COLLISIONLIVES_player_InBUS,
  input  logic [NUMROWS*DATAWIDTH-1:0] SC_COLLISIONLIVES_obstacle_InBUS,
  input  logic [NUMROWS-1:0]           SC_COLLISIONLIVES_rowEnable_InBUS,
  input  logic                         SC_COLLISIONLIVES_strobe_InLow,
  input  logic                         SC_COLLISIONLIVES_restart_InLow,
  output logic [NUMROWS-1:0]           SC_COLLISIONLIVES_rowHit_OutBUS,
  output logic                         SC_COLLISIONLIVES_hit_OutLow,
  output logic [2:0]                   SC_COLLISIONLIVES_lives_OutBUS,
  output logic                         SC_COLLISIONLIVES_OutLow
);
  typedef enum logic [1:0] {sPlay, sGrace, sOver} state_t;

  state_t             state;
  logic [2:0]         lives;
  logic [3:0]         graceCnt;
  logic [NUMROWS-1:0] collide;
  logic [NUMROWS-1:0] rowHit;
  logic               hit;
  logic               over;

  logic clk, rst, strobe, restart;
  assign clk     = SC_COLLISIONLIVES_CLOCK_50;
  assign rst     = SC_COLLISIONLIVES_RESET_InHigh;
  assign strobe  = SC_COLLISIONLIVES_strobe_InLow;
  assign restart = SC_COLLISIONLIVES_restart_InLow;

  for (genvar r = 0; r < NUMROWS; r++) begin : gRow
    sc_collision_lives_row #(.DATAWIDTH(DATAWIDTH)) uRow (
      .player   (SC_COLLISIONLIVES_player_InBUS[r*DATAWIDTH +: DATAWIDTH]),
      .obstacle (SC_COLLISIONLIVES_obstacle_InBUS[r*DATAWIDTH +: DATAWIDTH]),
      .enable   (SC_COLLISIONLIVES_rowEnable_InBUS[r]),
      .collide  (collide[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= sPlay;
      lives    <= 3'(LIVES);
      graceCnt <= '0;
      rowHit   <= '0;
      hit      <= 1'b0;
      over     <= 1'b0;
    end else begin
      hit <= 1'b0;
      // Collision map is captured on every strobe regardless of game state.
      if (strobe) rowHit <= collide;
      if (restart) begin
        state    <= sPlay;
        lives    <= 3'(LIVES);
        graceCnt <= '0;
        over     <= 1'b0;
      end else if (strobe) begin
        case (state)
          sPlay: begin
            if (|collide) begin
              hit <= 1'b1;
              if (lives <= 3'd1) begin
                lives <= 3'd0;
                state <= sOver;
                over  <= 1'b1;
              end else begin
                lives <= lives - 3'd1;
                if (GRACE > 0) begin
                  state    <= sGrace;
                  graceCnt <= 4'(GRACE);
                end
              end
            end
          end
          sGrace: begin
            if (graceCnt <= 4'd1) begin
              state    <= sPlay;
              graceCnt <= '0;
            end else begin
              graceCnt <= graceCnt - 4'd1;
            end
          end
          sOver: begin
          end
          default: state <= sPlay;
        endcase
      end
    end
  end

  assign SC_COLLISIONLIVES_rowHit_OutBUS = rowHit;
  assign SC_COLLISIONLIVES_hit_OutLow    = hit;
  assign SC_COLLISIONLIVES_lives_OutBUS  = lives;
  assign SC_COLLISIONLIVES_OutLow        = over;
endmodule

// File: tb/tb_sc_collision_lives.sv
// Bench for sc_collision_lives: table of vectors through a scoreboard queue,
// plus hand sequences for async reset mid-grace and the single-life game over.

module tb_sc_collision_lives;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pl, ob;
  logic [3:0]  en;
  logic        stb, rs;

  logic [3:0] rowHit0, rowHit1;
  logic       hit0, hit1, over0, over1;
  logic [2:0] lives0, lives1;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  sc_collision_lives dut0 (
    .SC_COLLISIONLIVES_CLOCK_50        (clk),
    .SC_COLLISIONLIVES_RESET_InHigh    (rst),
    .SC_COLLISIONLIVES_player_InBUS    (pl),
    .SC_COLLISIONLIVES_obstacle_InBUS  (ob),
    .SC_COLLISIONLIVES_rowEnable_InBUS (en),
    .SC_COLLISIONLIVES_strobe_InLow    (stb),
    .SC_COLLISIONLIVES_restart_InLow   (rs),
    .SC_COLLISIONLIVES_rowHit_OutBUS   (rowHit0),
    .SC_COLLISIONLIVES_hit_OutLow      (hit0),
    .SC_COLLISIONLIVES_lives_OutBUS    (lives0),
    .SC_COLLISIONLIVES_OutLow          (over0)
  );

  sc_collision_lives #(.LIVES(1), .GRACE(0)) dut1 (
    .SC_COLLISIONLIVES_CLOCK_50        (clk),
    .SC_COLLISIONLIVES_RESET_InHigh    (rst),
    .SC_COLLISIONLIVES_player_InBUS    (pl),
    .SC_COLLISIONLIVES_obstacle_InBUS  (ob),
    .SC_COLLISIONLIVES_rowEnable_InBUS (en),
    .SC_COLLISIONLIVES_strobe_InLow    (stb),
    .SC_COLLISIONLIVES_restart_InLow   (rs),
    .SC_COLLISIONLIVES_rowHit_OutBUS   (rowHit1),
    .SC_COLLISIONLIVES_hit_OutLow      (hit1),
    .SC_COLLISIONLIVES_lives_OutBUS    (lives1),
    .SC_COLLISIONLIVES_OutLow          (over1)
  );

  typedef struct {
    logic [31:0] pl, ob;
    logic [3:0]  en;
    logic        stb, rs;
    logic [3:0]  eRow;
    logic        eHit;
    logic [2:0]  eLives;
    logic        eOver;
  } vec_t;

  typedef struct {
    logic [3:0] row;
    logic       hit;
    logic [2:0] lives;
    logic       over;
  } exp_t;

  localparam logic [31:0] C2P = 32'h0010_0000;  // row 2 player 0x10
  localparam logic [31:0] C2O = 32'h0030_0000;  // row 2 obstacle 0x30

  vec_t vecs[16];
  exp_t sbq[$];

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] o, input logic [3:0] e,
                              input logic s, input logic r, input logic [3:0] eRow,
                              input logic eHit, input logic [2:0] eLives, input logic eOver);
    vec_t v;
    v.pl = p; v.ob = o; v.en = e; v.stb = s; v.rs = r;
    v.eRow = eRow; v.eHit = eHit; v.eLives = eLives; v.eOver = eOver;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] o, input logic [3:0] e,
                       input logic s, input logic r);
    @(negedge clk);
    pl = p; ob = o; en = e; stb = s; rs = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t ex;
    rst = 1'b1; pl = '0; ob = '0; en = 4'hF; stb = 1'b0; rs = 1'b0;

    vecs[0]  = mk(C2P, C2O, 4'hF, 1, 0, 4'b0100, 1, 3'd2, 0); // first hit -> grace
    vecs[1]  = mk(C2P, C2O, 4'hF, 0, 0, 4'b0100, 0, 3'd2, 0); // no strobe: hold
    vecs[2]  = mk(C2P, C2O, 4'hF, 1, 0, 4'b0100, 0, 3'd2, 0); // grace 2->1
    vecs[3]  = mk(C2P, C2O, 4'hF, 1, 0, 4'b0100, 0, 3'd2, 0); // grace exits
    vecs[4]  = mk(C2P, C2O, 4'hF, 1, 0, 4'b0100, 1, 3'd1, 0); // third strobe costs a life
    vecs[5]  = mk(32'h0, 32'h0, 4'hF, 1, 0, 4'b0000, 0, 3'd1, 0);
    vecs[6]  = mk(C2P, C2O, 4'b1011, 1, 0, 4'b0000, 0, 3'd1, 0); // masked, grace exits
    vecs[7]  = mk(C2P, C2O, 4'b1011, 1, 0, 4'b0000, 0, 3'd1, 0); // masked in play
    vecs[8]  = mk(C2P, C2O, 4'hF, 1, 1, 4'b0100, 0, 3'd3, 0);   // restart wins
    vecs[9]  = mk(C2P, C2O, 4'hF, 1, 0, 4'b0100, 1, 3'd2, 0);
    vecs[10] = mk(32'h0, 32'h0, 4'hF, 1, 0, 4'b0000, 0, 3'd2, 0);
    vecs[11] = mk(32'h0, 32'h0, 4'hF, 1, 0, 4'b0000, 0, 3'd2, 0); // back to play, lives 2
    vecs[12] = mk(C2P, C2O, 4'hF, 1, 1, 4'b0100, 0, 3'd3, 0);   // restart+hit in play
    vecs[13] = mk(32'hFF00_0001, 32'h0100_0001, 4'hF, 1, 0, 4'b1001, 1, 3'd2, 0);
    vecs[14] = mk(32'h0, 32'h0, 4'hF, 0, 0, 4'b1001, 0, 3'd2, 0);
    vecs[15] = mk(32'h0, 32'h0, 4'hF, 0, 1, 4'b1001, 0, 3'd3, 0); // restart keeps rowHit

    repeat (2) @(posedge clk);
    #1;
    check("reset rowHit", int'(rowHit0), 0);
    check("reset hit", int'(hit0), 0);
    check("reset lives", int'(lives0), 3);
    check("reset over", int'(over0), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      pl = vecs[i].pl; ob = vecs[i].ob; en = vecs[i].en; stb = vecs[i].stb; rs = vecs[i].rs;
      sbq.push_back('{vecs[i].eRow, vecs[i].eHit, vecs[i].eLives, vecs[i].eOver});
      @(posedge clk);
      #1;
      ex = sbq.pop_front();
      check($sformatf("v%0d rowHit", i), int'(rowHit0), int'(ex.row));
      check($sformatf("v%0d hit", i), int'(hit0), int'(ex.hit));
      check($sformatf("v%0d lives", i), int'(lives0), int'(ex.lives));
      check($sformatf("v%0d over", i), int'(over0), int'(ex.over));
    end

    // Enter grace, then pulse reset between clock edges.
    drive(C2P, C2O, 4'hF, 1, 0);
    check("pre-rst hit", int'(hit0), 1);
    check("pre-rst lives", int'(lives0), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async rowHit", int'(rowHit0), 0);
    check("async hit", int'(hit0), 0);
    check("async lives", int'(lives0), 3);
    check("async over", int'(over0), 0);
    check("async lives1", int'(lives1), 1);
    check("async over1", int'(over1), 0);
    drive(32'h0, 32'h0, 4'hF, 0, 0);
    rst = 1'b0;

    // First strobe after reset: dut0 loses a life, single-life dut1 is over.
    drive(C2P, C2O, 4'hF, 1, 0);
    check("post-rst hit", int'(hit0), 1);
    check("post-rst lives", int'(lives0), 2);
    check("over1 hit", int'(hit1), 1);
    check("over1 lives", int'(lives1), 0);
    check("over1 flag", int'(over1), 1);
    drive(32'h0, 32'h0, 4'hF, 1, 0);
    check("over1 rowHit clr", int'(rowHit1), 0);
    check("over1 hit gone", int'(hit1), 0);
    check("over1 held", int'(over1), 1);
    drive(C2P, C2O, 4'hF, 1, 0);
    check("over1 rowHit upd", int'(rowHit1), 4);
    check("over1 no hit", int'(hit1), 0);
    check("over1 lives0", int'(lives1), 0);
    check("over1 still", int'(over1), 1);
    drive(32'h0, 32'h0, 4'hF, 0, 1);
    check("restart1 lives", int'(lives1), 1);
    check("restart1 over", int'(over1), 0);
    check("restart1 rowHit", int'(rowHit1), 4);
    drive(32'h0, 32'h0, 4'hF, 0, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
